// File: rtl/cfu_initiator.sv
// CFU command initiator: queues host requests, issues one at a time, queues results/timeouts.
// Request-to-cmd_valid is 2 cycles; req_ready drops on a full request queue, issue stalls on a full result queue.

module cfu_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp;
   logic [AW:0]  rp;
   logic         full;
   logic         empty;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign count   = wp - rp;
   assign head    = mem[rp[AW-1:0]];
   // No bypass: a full FIFO refuses a push even when it pops in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wp[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + PTR_ONE;
         if (do_pop)  rp <= rp + PTR_ONE;
      end
   end
endmodule

module cfu_initiator #(
   parameter int REQ_DEPTH = 4,
   parameter int RES_DEPTH = 4,
   parameter int TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [9:0]  req_function_id,
   input  logic [31:0] req_inputs_0,
   input  logic [31:0] req_inputs_1,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_timeout,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [9:0]  cmd_payload_function_id,
   output logic [31:0] cmd_payload_inputs_0,
   output logic [31:0] cmd_payload_inputs_1,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [31:0] rsp_payload_outputs_0,
   output logic        busy,
   output logic        stray
);
   localparam int RQW = $clog2(REQ_DEPTH);
   localparam int RSW = $clog2(RES_DEPTH);
   localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [RQW:0]  REQ_FULL = (RQW + 1)'(REQ_DEPTH);
   localparam logic [RSW:0]  RES_FULL = (RSW + 1)'(RES_DEPTH);
   localparam logic [TW-1:0] T_ONE    = 1;
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state;
   logic [TW-1:0] timer;

   logic [73:0]  req_head;
   logic [RQW:0] req_count;
   logic         req_empty;
   logic         req_push;
   logic         req_pop;

   logic [32:0]  res_head;
   logic [32:0]  res_push_data;
   logic [RSW:0] res_count;
   logic         res_empty;
   logic         res_push;
   logic         res_pop;

   logic         rsp_fire;
   logic         timeout_hit;

   assign req_empty = (req_count == '0);
   assign req_ready = (req_count != REQ_FULL);
   assign req_push  = req_valid && req_ready;
   assign req_pop   = (state == ISSUE) && cmd_ready;

   assign rsp_fire    = rsp_valid && rsp_ready;
   assign timeout_hit = (TIMEOUT != 0) && (timer == T_LAST);
   // A response on the final timeout cycle still counts as a real result.
   assign res_push      = (state == WAIT) && (rsp_fire || timeout_hit);
   assign res_push_data = rsp_fire ? {1'b0, rsp_payload_outputs_0} : {1'b1, 32'd0};
   assign res_empty     = (res_count == '0);
   assign res_pop       = res_ready && !res_empty;

   cfu_fifo #(.W(74), .DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (req_push),
      .push_data ({req_function_id, req_inputs_1, req_inputs_0}),
      .pop       (req_pop),
      .head      (req_head),
      .count     (req_count)
   );

   cfu_fifo #(.W(33), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (res_push),
      .push_data (res_push_data),
      .pop       (res_pop),
      .head      (res_head),
      .count     (res_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         stray     <= 1'b0;
         rsp_ready <= 1'b0;
      end else begin
         rsp_ready <= 1'b1;
         if (rsp_fire && (state != WAIT)) stray <= 1'b1;
         case (state)
            IDLE: begin
               // Entering ISSUE reserves the result slot for this command.
               if (!req_empty && (res_count < RES_FULL)) state <= ISSUE;
            end
            ISSUE: begin
               if (cmd_ready) begin
                  state <= WAIT;
                  timer <= '0;
               end
            end
            WAIT: begin
               if (rsp_fire || timeout_hit) state <= IDLE;
               else                         timer <= timer + T_ONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_valid               = (state == ISSUE);
   assign cmd_payload_inputs_0    = cmd_valid ? req_head[31:0]  : 32'd0;
   assign cmd_payload_inputs_1    = cmd_valid ? req_head[63:32] : 32'd0;
   assign cmd_payload_function_id = cmd_valid ? req_head[73:64] : 10'd0;

   assign res_valid   = !res_empty;
   assign res_data    = res_valid ? res_head[31:0] : 32'd0;
   assign res_timeout = res_valid && res_head[32];
   assign busy        = (state != IDLE) || !req_empty;
endmodule

// File: tb/tb_cfu_initiator.sv
// Directed bench for cfu_initiator with a behavioural Fibonacci CFU (fib(0)=fib(1)=1).
module tb_cfu_initiator;
   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_function_id;
   logic [31:0] req_inputs_0;
   logic [31:0] req_inputs_1;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_timeout;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;
   logic        busy;
   logic        stray;

   logic        rv_cfu;
   logic        rv_stray;
   logic [31:0] rd_cfu;
   logic        rsp_en;
   int          rsp_delay;
   int          cmd_count;
   int          n_cmp;
   int          n_err;
   logic [31:0] q_data[$];
   logic        q_to[$];

   assign rsp_valid             = rv_cfu | rv_stray;
   assign rsp_payload_outputs_0 = rd_cfu;

   cfu_initiator #(.REQ_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(16)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_function_id         (req_function_id),
      .req_inputs_0            (req_inputs_0),
      .req_inputs_1            (req_inputs_1),
      .res_valid               (res_valid),
      .res_ready               (res_ready),
      .res_data                (res_data),
      .res_timeout             (res_timeout),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (cmd_payload_function_id),
      .cmd_payload_inputs_0    (cmd_payload_inputs_0),
      .cmd_payload_inputs_1    (cmd_payload_inputs_1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_payload_outputs_0),
      .busy                    (busy),
      .stray                   (stray)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] fib(input logic [31:0] n);
      logic [31:0] a = 1;
      logic [31:0] b = 1;
      logic [31:0] t;
      for (int i = 2; i <= int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   // Behavioural CFU: a command accepted at edge C answers on edge C+1+rsp_delay.
   initial begin
      logic        pend;
      int          cnt;
      logic [31:0] pdata;
      pend = 0; cnt = 0; pdata = 0;
      rv_cfu = 0; rd_cfu = 0; cmd_count = 0;
      forever begin
         @(negedge clk);
         if (reset) pend = 0;
         else if (cmd_valid && cmd_ready) begin
            cmd_count++;
            if (rsp_en) begin
               pend  = 1;
               cnt   = rsp_delay;
               pdata = fib(cmd_payload_inputs_0);
            end
         end
         @(posedge clk);
         #1;
         rv_cfu = 0;
         if (pend) begin
            if (cnt == 0) begin
               rv_cfu = 1;
               rd_cfu = pdata;
               pend   = 0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (res_valid && res_ready) begin
            q_data.push_back(res_data);
            q_to.push_back(res_timeout);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a);
      logic ok;
      ok = 0;
      req_valid       = 1;
      req_inputs_0    = a;
      req_inputs_1    = ~a;
      req_function_id = a[9:0];
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
         tick();
      end
      req_valid = 0;
      chk("send_accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_q(input int n, input int budget);
      int i;
      i = 0;
      while (q_data.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("q_fill", q_data.size(), n);
   endtask

   task automatic clear_q();
      q_data.delete();
      q_to.delete();
   endtask

   initial begin
      logic [31:0] exp_fib [5];
      logic [31:0] exp_bp  [6];
      int          c0;
      exp_fib = '{32'd1, 32'd1, 32'd2, 32'd8, 32'd89};
      exp_bp  = '{32'd3, 32'd5, 32'd13, 32'd21, 32'd34, 32'd55};
      n_cmp = 0; n_err = 0;
      reset = 1; req_valid = 0; req_function_id = 0; req_inputs_0 = 0; req_inputs_1 = 0;
      res_ready = 0; cmd_ready = 0; rv_stray = 0; rsp_en = 1; rsp_delay = 0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_rsp_ready", rsp_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_timeout", res_timeout, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stray", stray, 0);
      chk("rst_req_ready", req_ready, 1);
      tick();
      reset = 0;
      @(negedge clk);
      @(negedge clk);
      chk("post_rsp_ready", rsp_ready, 1);
      tick();

      // Fibonacci requests back-to-back
      res_ready = 1; cmd_ready = 1;
      clear_q();
      send(0); send(1); send(2); send(5); send(10);
      @(negedge clk);
      chk("fib_busy", busy, 1);
      wait_q(5, 300);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("fib_data%0d", i), q_data[i], exp_fib[i]);
         chk($sformatf("fib_to%0d", i), {31'd0, q_to[i]}, 0);
      end
      chk("fib_busy_done", busy, 0);
      tick();

      // Result backpressure: only RES_DEPTH commands may be outstanding
      clear_q();
      res_ready = 0; cmd_ready = 0;
      c0 = cmd_count;
      send(3); send(4); send(6); send(7);
      @(negedge clk);
      chk("bp_req_full", req_ready, 0);
      chk("bp_cmd_held", cmd_valid, 1);
      tick();
      cmd_ready = 1;
      send(8); send(9);
      repeat (60) @(negedge clk);
      chk("bp_cmd_count", cmd_count - c0, 4);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_req_ready", req_ready, 1);
      chk("bp_busy", busy, 1);
      chk("bp_no_pop", q_data.size(), 0);
      tick();
      res_ready = 1;
      wait_q(6, 400);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("bp_data%0d", i), q_data[i], exp_bp[i]);
         chk($sformatf("bp_to%0d", i), {31'd0, q_to[i]}, 0);
      end
      tick();

      // Latency and timeout with a silent responder
      clear_q();
      res_ready = 0; rsp_en = 0;
      req_valid = 1; req_inputs_0 = 32'd7; req_inputs_1 = 32'hA5A5_0001; req_function_id = 10'h2AB;
      @(negedge clk);
      chk("lat_req_ready", req_ready, 1);
      tick();
      req_valid = 0;
      @(negedge clk);
      chk("lat_n1_cmd", cmd_valid, 0);
      @(negedge clk);
      chk("lat_n2_cmd", cmd_valid, 1);
      chk("lat_fid", {22'd0, cmd_payload_function_id}, 32'h2AB);
      chk("lat_in0", cmd_payload_inputs_0, 32'd7);
      chk("lat_in1", cmd_payload_inputs_1, 32'hA5A5_0001);
      @(negedge clk);
      chk("wait_cmd_low", cmd_valid, 0);
      chk("wait_payload0", cmd_payload_inputs_0, 0);
      chk("wait_busy", busy, 1);
      repeat (15) @(negedge clk);
      chk("to_early", res_valid, 0);
      @(negedge clk);
      chk("to_valid", res_valid, 1);
      chk("to_flag", res_timeout, 1);
      chk("to_data", res_data, 0);
      chk("to_busy", busy, 0);
      tick();
      res_ready = 1;
      tick();
      @(negedge clk);
      chk("to_popped", res_valid, 0);
      chk("to_q_size", q_data.size(), 1);
      chk("to_q_flag", {31'd0, q_to[0]}, 1);
      tick();

      // Next request issues normally after a timeout
      clear_q();
      rsp_en = 1; rsp_delay = 0;
      send(5);
      wait_q(1, 100);
      chk("after_to_data", q_data[0], 8);
      chk("after_to_flag", {31'd0, q_to[0]}, 0);
      tick();

      // Response arriving on the timeout cycle wins
      clear_q();
      rsp_delay = 15;
      send(6);
      wait_q(1, 100);
      chk("edge_data", q_data[0], 13);
      chk("edge_flag", {31'd0, q_to[0]}, 0);
      repeat (30) @(negedge clk);
      chk("edge_single", q_data.size(), 1);
      chk("edge_no_stray", stray, 0);
      tick();

      // Stray response while IDLE
      clear_q();
      rsp_delay = 0;
      rv_stray = 1;
      tick();
      rv_stray = 0;
      @(negedge clk);
      chk("stray_set", stray, 1);
      chk("stray_res_valid", res_valid, 0);
      repeat (5) @(negedge clk);
      chk("stray_nothing", q_data.size(), 0);
      chk("stray_sticky", stray, 1);
      tick();

      // Reset in WAIT with three requests queued
      clear_q();
      rsp_en = 0; res_ready = 0;
      send(11); send(12); send(13); send(14);
      @(negedge clk);
      chk("mid_busy", busy, 1);
      tick();
      reset = 1;
      tick();
      reset = 0;
      @(negedge clk);
      chk("mid_cmd_valid", cmd_valid, 0);
      chk("mid_res_valid", res_valid, 0);
      chk("mid_busy_clr", busy, 0);
      chk("mid_stray_clr", stray, 0);
      chk("mid_rsp_ready", rsp_ready, 0);
      chk("mid_req_ready", req_ready, 1);
      @(negedge clk);
      chk("mid_rsp_ready_up", rsp_ready, 1);
      tick();
      rsp_en = 1; res_ready = 1;
      c0 = cmd_count;
      repeat (40) @(negedge clk);
      chk("mid_no_stale", q_data.size(), 0);
      chk("mid_no_cmd", cmd_count - c0, 0);
      chk("mid_idle_res", res_valid, 0);
      chk("mid_idle_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
